// File: rtl/draw_background_param_if.sv
// Timing bundle plus background controls, in and out of the background stage.
interface draw_background_param_if #(
    parameter int CNT_W = 11,
    parameter int RGB_W = 12
);
    logic [CNT_W-1:0] hcount_in;
    logic [CNT_W-1:0] vcount_in;
    logic             hsync_in;
    logic             vsync_in;
    logic             hblnk_in;
    logic             vblnk_in;
    logic [1:0]       mode_in;
    logic             scroll_en;
    logic [CNT_W-1:0] hcount_out;
    logic [CNT_W-1:0] vcount_out;
    logic             hsync_out;
    logic             vsync_out;
    logic             hblnk_out;
    logic             vblnk_out;
    logic [RGB_W-1:0] rgb_out;
    logic [7:0]       frame_cnt_out;

    modport master (
        output hcount_in, vcount_in, hsync_in, vsync_in,
        output hblnk_in, vblnk_in, mode_in, scroll_en,
        input  hcount_out, vcount_out, hsync_out, vsync_out,
        input  hblnk_out, vblnk_out, rgb_out, frame_cnt_out
    );

    modport slave (
        input  hcount_in, vcount_in, hsync_in, vsync_in,
        input  hblnk_in, vblnk_in, mode_in, scroll_en,
        output hcount_out, vcount_out, hsync_out, vsync_out,
        output hblnk_out, vblnk_out, rgb_out, frame_cnt_out
    );
endinterface

// File: rtl/draw_background_param.sv
// Parametrised VGA background: solid, frame, checkerboard or colour bars,
// with mode and scroll latched only on the vblank rising edge.
module draw_background_param #(
    parameter int               CNT_W     = 11,
    parameter int               RGB_W     = 12,
    parameter int               H_ACTIVE  = 1024,
    parameter int               V_ACTIVE  = 768,
    parameter int               BORDER    = 1,
    parameter int               CELL_LOG2 = 5,
    parameter int               BAR_LOG2  = 7,
    parameter int               PIPE      = 1,
    parameter logic [RGB_W-1:0] BLANK_RGB = RGB_W'(12'h333),
    parameter logic [RGB_W-1:0] FILL_RGB  = RGB_W'(12'h000)
) (
    input logic pclk,
    input logic rst,
    draw_background_param_if.slave bus
);
    localparam int CH_W = RGB_W / 3;
    localparam logic [CNT_W-1:0] H_ACT = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] BRD   = CNT_W'(BORDER);
    localparam logic [CNT_W-1:0] H_LO  = CNT_W'(H_ACTIVE - BORDER);
    localparam logic [CNT_W-1:0] V_LO  = CNT_W'(V_ACTIVE - BORDER);

    typedef enum logic [1:0] {
        SOLID   = 2'd0,
        FRAME   = 2'd1,
        CHECKER = 2'd2,
        BARS    = 2'd3
    } mode_t;

    typedef struct packed {
        logic [CNT_W-1:0] h;
        logic [CNT_W-1:0] v;
        logic             hs;
        logic             vs;
        logic             hb;
        logic             vb;
        logic [RGB_W-1:0] rgb;
        logic [7:0]       fc;
    } pix_t;

    mode_t            mode_q, mode_d;
    logic [CNT_W-1:0] offset_q, offset_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             vblnk_prev_q, vblnk_prev_d;
    pix_t [PIPE-1:0]  pipe_q, pipe_d;

    logic             frame_edge;
    logic [CNT_W-1:0] hs;
    logic [2:0]       bar;
    logic [RGB_W-1:0] rgb_c;
    logic             unused_hs;

    function automatic logic [RGB_W-1:0] col(
        input logic r, input logic g, input logic b
    );
        return {{CH_W{r}}, {CH_W{g}}, {CH_W{b}}};
    endfunction

    assign frame_edge = bus.vblnk_in & ~vblnk_prev_q;
    assign hs         = bus.hcount_in + offset_q;
    assign bar        = hs[BAR_LOG2+2 -: 3];
    assign unused_hs  = ^hs;

    always_comb begin
        mode_d       = mode_q;
        offset_d     = offset_q;
        frame_cnt_d  = frame_cnt_q;
        vblnk_prev_d = bus.vblnk_in;
        if (frame_edge) begin
            mode_d      = mode_t'(bus.mode_in);
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (bus.scroll_en)
                offset_d = offset_q + CNT_W'(1);
        end
    end

    always_comb begin
        rgb_c = FILL_RGB;
        if (bus.hblnk_in || bus.vblnk_in) begin
            rgb_c = BLANK_RGB;
        end else if (bus.hcount_in >= H_ACT || bus.vcount_in >= V_ACT) begin
            rgb_c = FILL_RGB;
        end else begin
            unique case (mode_q)
                SOLID: rgb_c = FILL_RGB;
                FRAME: begin
                    if (bus.vcount_in < BRD)
                        rgb_c = col(1'b0, 1'b0, 1'b1);
                    else if (bus.vcount_in >= V_LO)
                        rgb_c = col(1'b1, 1'b0, 1'b1);
                    else if (bus.hcount_in < BRD)
                        rgb_c = col(1'b0, 1'b1, 1'b0);
                    else if (bus.hcount_in >= H_LO)
                        rgb_c = col(1'b1, 1'b0, 1'b0);
                    else
                        rgb_c = FILL_RGB;
                end
                CHECKER: begin
                    rgb_c = (hs[CELL_LOG2] ^ bus.vcount_in[CELL_LOG2])
                          ? '1 : '0;
                end
                BARS: rgb_c = col(~bar[1], ~bar[2], ~bar[0]);
                default: rgb_c = FILL_RGB;
            endcase
        end
    end

    // Stage 0 carries the freshly painted pixel; later stages only delay.
    always_comb begin
        pipe_d       = pipe_q;
        pipe_d[0].h  = bus.hcount_in;
        pipe_d[0].v  = bus.vcount_in;
        pipe_d[0].hs = bus.hsync_in;
        pipe_d[0].vs = bus.vsync_in;
        pipe_d[0].hb = bus.hblnk_in;
        pipe_d[0].vb = bus.vblnk_in;
        pipe_d[0].rgb = rgb_c;
        pipe_d[0].fc = frame_cnt_q;
        for (int i = 1; i < PIPE; i++)
            pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            mode_q       <= FRAME;
            offset_q     <= '0;
            frame_cnt_q  <= '0;
            vblnk_prev_q <= 1'b1;
            pipe_q       <= '0;
        end else begin
            mode_q       <= mode_d;
            offset_q     <= offset_d;
            frame_cnt_q  <= frame_cnt_d;
            vblnk_prev_q <= vblnk_prev_d;
            pipe_q       <= pipe_d;
        end
    end

    assign bus.hcount_out    = pipe_q[PIPE-1].h;
    assign bus.vcount_out    = pipe_q[PIPE-1].v;
    assign bus.hsync_out     = pipe_q[PIPE-1].hs;
    assign bus.vsync_out     = pipe_q[PIPE-1].vs;
    assign bus.hblnk_out     = pipe_q[PIPE-1].hb;
    assign bus.vblnk_out     = pipe_q[PIPE-1].vb;
    assign bus.rgb_out       = pipe_q[PIPE-1].rgb;
    assign bus.frame_cnt_out = pipe_q[PIPE-1].fc;
endmodule

// File: doc/draw_background_param.md
# draw_background_param

Parametrised VGA background stage, the next generation of the fixed-colour background drawer. It sits directly after the timing generator, ahead of all sprite and overlay stages. It passes the VGA timing bundle through a configurable-depth pipeline and paints one of four background modes: solid, border frame, checkerboard or colour bars. Mode changes and horizontal scrolling are applied only at frame boundaries, so a frame is never torn.

## Interface
Parameters:
- CNT_W, 11: width of hcount/vcount.
- RGB_W, 12: rgb width; must be a multiple of 3; each channel is RGB_W/3 bits.
- H_ACTIVE, 1024: active pixels per line.
- V_ACTIVE, 768: active lines per frame.
- BORDER, 1: frame-mode border thickness in pixels; legal range 1..V_ACTIVE/2.
- CELL_LOG2, 5: checkerboard cell size is 2^CELL_LOG2 pixels.
- BAR_LOG2, 7: colour-bar width is 2^BAR_LOG2 pixels.
- PIPE, 1: output latency in cycles; legal range 1..4.
- BLANK_RGB, 12'h333: colour driven during blanking.
- FILL_RGB, 12'h000: solid and interior fill colour.

Ports:
- pclk, in, 1: pixel clock; the only clock.
- rst, in, 1: reset. **One clock; reset is asynchronous and active-low.**
- hcount_in, vcount_in, in, CNT_W each: pixel position.
- hsync_in, vsync_in, hblnk_in, vblnk_in, in, 1 each: timing signals.
- mode_in, in, 2: requested mode. 0 = SOLID, 1 = FRAME, 2 = CHECKER, 3 = BARS.
- scroll_en, in, 1: advance the scroll offset once per frame.
- hcount_out, vcount_out, out, CNT_W each: delayed copies of the inputs.
- hsync_out, vsync_out, hblnk_out, vblnk_out, out, 1 each: delayed copies of the inputs.
- rgb_out, out, RGB_W: background pixel.
- frame_cnt_out, out, 8: frame counter; wraps 255 to 0.

## Operation
Frame boundary:
- A frame boundary is a rising edge of vblnk_in, detected against a registered vblnk_prev.
- On each boundary, mode_reg takes the value of mode_in.
- On each boundary, frame_cnt increments.
- On each boundary, offset increments by 1 (modulo 2^CNT_W) if scroll_en is 1; otherwise offset holds.
- mode_in and scroll_en are ignored at all other times.

Pixel colour, evaluated in priority order from the current inputs, mode_reg and offset:
1. hblnk_in or vblnk_in is high: BLANK_RGB.
2. hcount_in ≥ H_ACTIVE or vcount_in ≥ V_ACTIVE: FILL_RGB.
3. SOLID: FILL_RGB.
4. FRAME, first matching rule wins:
   - v < BORDER: blue (0_0_f).
   - v ≥ V_ACTIVE−BORDER: magenta (f_0_f).
   - h < BORDER: green (0_f_0).
   - h ≥ H_ACTIVE−BORDER: red (f_0_0).
   - otherwise: FILL_RGB.
5. CHECKER, with hs = (hcount_in + offset) truncated to CNT_W bits:
   - hs[CELL_LOG2] XOR vcount_in[CELL_LOG2] = 1: all-ones (white).
   - otherwise: zero.
6. BARS: i = hs[BAR_LOG2+2:BAR_LOG2]. Each channel is full-scale or zero:
   - i = 0..7 gives white, yellow, cyan, green, magenta, red, blue, black.
   - r = ~i[2], g = ~i[1]^… is not used; the exact mapping is i → {r,g,b} = 0:111, 1:110, 2:011, 3:010, 4:101, 5:100, 6:001, 7:000.

Offset scope:
- offset does not affect FRAME or SOLID.

## Timing
Reset (rst low, asynchronous):
- All outputs are 0.
- All pipeline registers are 0.
- mode_reg = 1 (FRAME); offset = 0; frame_cnt = 0.
- vblnk_prev = 1, so a frame that is already in blanking at reset release does not count as an edge.

Latency and pipeline:
- Every output lags its input by exactly PIPE cycles. Timing signals and rgb stay mutually aligned.
- With PIPE = 1 the stage behaves as a single register stage.
- The rgb for a pixel is computed in the cycle it is presented at the input; stages 2..PIPE are pure delay.

Boundary-edge timing:
- Given an edge at input cycle t, mode_reg, offset and frame_cnt update at the clock edge ending cycle t. They take effect from pixel t+1 onward.
- Pixel t is blanked in any case, so the update is never visible mid-frame.
- frame_cnt_out equals frame_cnt delayed by PIPE cycles, aligned with vblnk_out.
- If mode_in changes in the same cycle as the edge, the new value is captured.
- If vblnk_in is held high for many cycles, only one increment occurs.

Reset mid-frame:
- Outputs go to 0 immediately.
- After release, the first valid output appears PIPE cycles later.

## Test plan
- Reset then release with vblnk_in = 1 → frame_cnt_out stays 0 until vblnk_in falls and rises again; rgb_out = 0 during reset, 12'h333 PIPE cycles after release.
- FRAME, BORDER = 2, PIPE = 1 → (h=0,v=0) gives 00f, (5,767) gives f0f, (1,100) gives 0f0, (1022,100) gives f00, (500,500) gives 000, hblnk gives 333; each appears 1 cycle after input.
- CHECKER, scroll_en = 0 → (31,0) gives 000, (32,0) gives fff, (32,32) gives 000.
- CHECKER, scroll_en = 1 over 3 frames → offset = 3, so (29,0) gives fff; frame_cnt_out = 3.
- BARS, PIPE = 3 → h = 0, 128, 384, 896 give fff, ff0, 0f0, 000; all timing outputs delayed exactly 3 cycles.
- Toggle mode_in from 1 to 2 mid-frame → no change until the next vblnk rising edge, then the following frame is checkerboard.
- Offset wrap: start at 2047 → the next boundary gives 0.
